conv_window_feeder: RTL and testbench

//  Upstream stage of the conv PE. Reads one single-channel int8 feature map from an activation BRAM.

---
 rtl/cnn_pkg.sv | 30 +++
 rtl/feeder_row_buf.sv | 82 ++++++++
 rtl/conv_window_feeder.sv | 218 +++++++++++++++++++++
 tb/tb_conv_window_feeder.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: constants shared by the conv datapath (window feeder, PE, weight
// path) plus the window feeder state encoding.
//   PIX_W    bits per pixel / weight
//   WORD_PIX pixels per activation BRAM word
//   WORD_W   activation BRAM word width
//   WIN_W    width of one 3x3 window / weight word
//   KSIZE    kernel edge length
package cnn_pkg;

  localparam int PIX_W    = 8;
  localparam int WORD_PIX = 8;
  localparam int WORD_W   = 64;
  localparam int WIN_W    = 72;
  localparam int KSIZE    = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_EMIT  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } feeder_state_e;

  // Byte slot of kernel tap (row, col) inside a window / weight word.
  // The PE relies on both operands using this same ordering.
  function automatic int win_byte_idx(input int row, input int col);
    return KSIZE * row + col;
  endfunction

endpackage

// File: rtl/feeder_row_buf.sv
// feeder_row_buf: three map rows (R0..R2) of IMG_W bytes each, with a
// word-wide write port, a one-cycle upward shift (R0<=R1, R1<=R2) and a
// registered 3x3 tap starting at a byte column.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   shift_en            move rows up by one (R2 keeps its old contents)
//   wr_en/wr_row/wr_word/wr_data  write one 64-bit word into a row
//   tap_en/tap_col      reload the window register for column tap_col
//   tap_data            registered 72-bit window
module feeder_row_buf
  import cnn_pkg::*;
#(
  parameter int IMG_W      = 32,
  parameter int WORD_IDX_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_en,
  input  logic                  wr_en,
  input  logic [1:0]            wr_row,
  input  logic [WORD_IDX_W-1:0] wr_word,
  input  logic [WORD_W-1:0]     wr_data,
  input  logic                  tap_en,
  input  logic [7:0]            tap_col,
  output logic [WIN_W-1:0]      tap_data
);

  localparam int ROW_BITS = IMG_W * PIX_W;

  logic [ROW_BITS-1:0] row_r     [KSIZE];
  logic [ROW_BITS-1:0] row_nxt_s [KSIZE];
  logic [WIN_W-1:0]    tap_s;

  // Next row contents: optional shift, then optional word write.
  always_comb begin
    for (int r = 0; r < KSIZE; r++) begin
      row_nxt_s[r] = row_r[r];
    end
    if (shift_en) begin
      row_nxt_s[0] = row_r[1];
      row_nxt_s[1] = row_r[2];
    end else begin
      row_nxt_s[0] = row_r[0];
      row_nxt_s[1] = row_r[1];
    end
    if (wr_en && (wr_row < 2'd3)) begin
      row_nxt_s[wr_row][int'(wr_word) * WORD_W +: WORD_W] = wr_data;
    end else begin
      row_nxt_s[2] = row_nxt_s[2];
    end
  end

  // Window tap taken from the next-state rows so a word captured on the
  // same edge as the tap reload is already visible in the window.
  always_comb begin
    tap_s = '0;
    for (int i = 0; i < KSIZE; i++) begin
      for (int j = 0; j < KSIZE; j++) begin
        tap_s[PIX_W * win_byte_idx(i, j) +: PIX_W] =
          row_nxt_s[i][PIX_W * (int'(tap_col) + j) +: PIX_W];
      end
    end
  end

  // Row storage and window output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < KSIZE; r++) begin
        row_r[r] <= '0;
      end
      tap_data <= '0;
    end else begin
      for (int r = 0; r < KSIZE; r++) begin
        row_r[r] <= row_nxt_s[r];
      end
      if (tap_en) begin
        tap_data <= tap_s;
      end
    end
  end

endmodule

// File: rtl/conv_window_feeder.sv
// conv_window_feeder: reads a single-channel int8 feature map (8 pixels per
// 64-bit BRAM word) and emits every 3x3 stride-1 no-padding window under
// valid/ready, in weight-ROM byte order.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   start, base_addr     frame start pulse and word address of pixel (0,0)
//   busy, done           frame in progress / one-cycle completion pulse
//   bram_en, bram_addr   BRAM read port request
//   bram_dout            BRAM read data, one cycle after bram_en
//   win_valid, win_ready window handshake
//   win_data             byte 3*i+j = pixel(win_x+j, win_y+i)
//   win_x, win_y         window top-left position
//   win_last             final window of the frame
module conv_window_feeder
  import cnn_pkg::*;
#(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [WORD_W-1:0] bram_dout,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [WIN_W-1:0]  win_data,
  output logic [7:0]        win_x,
  output logic [7:0]        win_y,
  output logic              win_last
);

  localparam int WPR        = IMG_W / WORD_PIX;
  localparam int LOAD_READS = KSIZE * WPR;
  localparam int CNT_W      = $clog2(LOAD_READS + 1);
  localparam int WORD_IDX_W = (WPR > 1) ? $clog2(WPR) : 1;

  localparam logic [CNT_W-1:0]      LOAD_N    = CNT_W'(LOAD_READS);
  localparam logic [CNT_W-1:0]      SHIFT_N   = CNT_W'(WPR);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [WORD_IDX_W-1:0] WORD_LAST = WORD_IDX_W'(WPR - 1);
  localparam logic [WORD_IDX_W-1:0] WORD_ONE  = WORD_IDX_W'(1);
  localparam logic [7:0]            X_LAST    = 8'(IMG_W - KSIZE);
  localparam logic [7:0]            Y_LAST    = 8'(IMG_H - KSIZE);

  if ((IMG_W % WORD_PIX) != 0 || IMG_W < WORD_PIX || IMG_H < KSIZE || IMG_W > 256) begin : g_cfg_err
    $fatal(1, "conv_window_feeder: unsupported IMG_W=%0d IMG_H=%0d", IMG_W, IMG_H);
  end

  feeder_state_e           state_r;
  feeder_state_e           state_nxt_s;
  logic [CNT_W-1:0]        rd_cnt_r;
  logic [CNT_W-1:0]        cap_cnt_r;
  logic [CNT_W-1:0]        phase_reads_s;
  logic [1:0]              cap_row_r;
  logic [WORD_IDX_W-1:0]   cap_word_r;
  logic                    rd_pend_r;
  logic [ADDR_W-1:0]       addr_r;
  logic                    issue_s;
  logic                    capture_s;
  logic                    last_cap_s;
  logic                    hs_s;
  logic                    shift_s;
  logic                    start_ok_s;
  logic                    tap_en_s;
  logic [7:0]              x_nxt_s;
  logic [7:0]              y_nxt_s;

  // Next state, read issue, row shift and window position.
  always_comb begin
    state_nxt_s   = state_r;
    issue_s       = 1'b0;
    shift_s       = 1'b0;
    start_ok_s    = 1'b0;
    x_nxt_s       = win_x;
    y_nxt_s       = win_y;
    hs_s          = win_valid && win_ready;
    capture_s     = rd_pend_r;
    phase_reads_s = (state_r == ST_LOAD) ? LOAD_N : SHIFT_N;
    last_cap_s    = rd_pend_r && (cap_cnt_r == (phase_reads_s - CNT_ONE));
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_LOAD;
          start_ok_s  = 1'b1;
          x_nxt_s     = 8'd0;
          y_nxt_s     = 8'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        issue_s = (rd_cnt_r < phase_reads_s);
        if (last_cap_s) begin
          state_nxt_s = ST_EMIT;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_EMIT: begin
        if (hs_s) begin
          if (win_x == X_LAST) begin
            x_nxt_s = 8'd0;
            if (win_y == Y_LAST) begin
              state_nxt_s = ST_DONE;
            end else begin
              state_nxt_s = ST_SHIFT;
              y_nxt_s     = win_y + 8'd1;
            end
          end else begin
            x_nxt_s = win_x + 8'd1;
          end
        end else begin
          state_nxt_s = ST_EMIT;
        end
      end
      ST_SHIFT: begin
        issue_s = (rd_cnt_r < phase_reads_s);
        // The first SHIFT cycle moves the rows up; the new row's first word
        // lands two edges later, so shift and write never coincide.
        shift_s = (rd_cnt_r == '0);
        if (last_cap_s) begin
          state_nxt_s = ST_EMIT;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    tap_en_s = (state_nxt_s == ST_EMIT);
  end

  // FSM state, BRAM request, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      rd_cnt_r   <= '0;
      cap_cnt_r  <= '0;
      cap_row_r  <= 2'd0;
      cap_word_r <= '0;
      rd_pend_r  <= 1'b0;
      addr_r     <= '0;
      bram_en    <= 1'b0;
      bram_addr  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      win_valid  <= 1'b0;
      win_x      <= 8'd0;
      win_y      <= 8'd0;
      win_last   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      bram_en   <= issue_s;
      rd_pend_r <= bram_en;
      if (start_ok_s) begin
        addr_r <= base_addr;
      end else if (issue_s) begin
        // Rows are contiguous, so one running address covers LOAD and every
        // SHIFT; it wraps modulo 2^ADDR_W on its own.
        bram_addr <= addr_r;
        addr_r    <= addr_r + ADDR_W'(1);
      end
      if (state_r == ST_LOAD || state_r == ST_SHIFT) begin
        if (issue_s) begin
          rd_cnt_r <= rd_cnt_r + CNT_ONE;
        end
        if (capture_s) begin
          cap_cnt_r <= cap_cnt_r + CNT_ONE;
          if (cap_word_r == WORD_LAST) begin
            cap_word_r <= '0;
            cap_row_r  <= cap_row_r + 2'd1;
          end else begin
            cap_word_r <= cap_word_r + WORD_ONE;
          end
        end
      end else begin
        rd_cnt_r   <= '0;
        cap_cnt_r  <= '0;
        cap_word_r <= '0;
        cap_row_r  <= (state_nxt_s == ST_SHIFT) ? 2'd2 : 2'd0;
      end
      win_x     <= x_nxt_s;
      win_y     <= y_nxt_s;
      win_valid <= (state_nxt_s == ST_EMIT);
      win_last  <= (state_nxt_s == ST_EMIT) && (x_nxt_s == X_LAST) && (y_nxt_s == Y_LAST);
      busy      <= (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_EMIT) ||
                   (state_nxt_s == ST_SHIFT);
      done      <= (state_nxt_s == ST_DONE);
    end
  end

  feeder_row_buf #(
    .IMG_W      (IMG_W),
    .WORD_IDX_W (WORD_IDX_W)
  ) u_row_buf (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_s),
    .wr_en    (capture_s),
    .wr_row   (cap_row_r),
    .wr_word  (cap_word_r),
    .wr_data  (bram_dout),
    .tap_en   (tap_en_s),
    .tap_col  (x_nxt_s),
    .tap_data (win_data)
  );

endmodule

// File: tb/tb_conv_window_feeder.sv
// Scoreboard bench for conv_window_feeder: a 32x32 instance and an 8x3
// instance, each fed by a 1-cycle-latency BRAM model whose pixel(x,y) is
// (y*32+x) & 8'hFF relative to the frame base address.
module tb_conv_window_feeder;

  typedef struct packed {
    logic [71:0] data;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        last;
  } win_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start, start2;
  logic [11:0] base_addr, base_addr2;
  logic        busy, done, busy2, done2;
  logic        bram_en, bram_en2;
  logic [11:0] bram_addr, bram_addr2;
  logic [63:0] bram_dout, bram_dout2;
  logic        win_valid, win_valid2;
  logic        win_ready = 1'b1;
  logic        win_ready2;
  logic [71:0] win_data, win_data2;
  logic [7:0]  win_x, win_y, win_x2, win_y2;
  logic        win_last, win_last2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int s_cyc = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int done2_cnt = 0;
  bit first_pending = 1'b0;
  bit first_rd_pending = 1'b0;
  bit rand_ready = 1'b0;
  bit saw_wrap = 1'b0;
  bit stall_r = 1'b0;
  logic [11:0] prev_addr = 12'h000;
  logic [11:0] base_cur = 12'h000;
  logic [11:0] base2 = 12'h010;
  win_t held;
  win_t q[$];
  win_t q2[$];

  conv_window_feeder #(.IMG_W(32), .IMG_H(32), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .busy(busy), .done(done),
    .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_x(win_x), .win_y(win_y), .win_last(win_last)
  );

  conv_window_feeder #(.IMG_W(8), .IMG_H(3), .ADDR_W(12)) dut_small (
    .clk(clk), .rst(rst), .start(start2), .base_addr(base_addr2), .busy(busy2), .done(done2),
    .bram_en(bram_en2), .bram_addr(bram_addr2), .bram_dout(bram_dout2),
    .win_valid(win_valid2), .win_ready(win_ready2), .win_data(win_data2),
    .win_x(win_x2), .win_y(win_y2), .win_last(win_last2)
  );

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] bram_word(input logic [11:0] a, input logic [11:0] b, input int w);
    logic [11:0] d;
    int off, wpr, y, xb;
    logic [63:0] r;
    d = a - b;
    off = int'(d);
    wpr = w / 8;
    y = off / wpr;
    xb = (off % wpr) * 8;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = 8'((y * 32 + xb + k) & 255);
    return r;
  endfunction

  function automatic logic [71:0] exp_win(input int x, input int y);
    logic [71:0] r;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        r[8*(3*i+j) +: 8] = 8'(((y + i) * 32 + x + j) & 255);
    return r;
  endfunction

  task automatic push_frame();
    win_t e;
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 30; x++) begin
        e.data = exp_win(x, y);
        e.x = 8'(x);
        e.y = 8'(y);
        e.last = (x == 29) && (y == 29);
        q.push_back(e);
      end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (bram_en) bram_dout <= bram_word(bram_addr, base_cur, 32);
  always @(posedge clk) if (bram_en2) bram_dout2 <= bram_word(bram_addr2, base2, 8);

  always @(posedge clk) begin
    #1;
    win_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor for the 32x32 instance.
  always @(negedge clk) begin
    win_t e;
    if (!rst) begin
      stall_r = 1'b0;
    end else begin
      if (stall_r) begin
        chk("stall_valid", 72'(win_valid), 72'd1);
        chk("stall_data", win_data, held.data);
        chk("stall_x", 72'(win_x), 72'(held.x));
        chk("stall_y", 72'(win_y), 72'(held.y));
        chk("stall_last", 72'(win_last), 72'(held.last));
      end
      if (win_valid && first_pending) begin
        chk("first_valid_cycle", 72'(cyc - s_cyc), 72'd14);
        first_pending = 1'b0;
      end
      if (bram_en && first_rd_pending) begin
        chk("first_read_cycle", 72'(cyc - s_cyc), 72'd1);
        first_rd_pending = 1'b0;
      end
      if (bram_en) begin
        if (bram_addr == 12'h000 && prev_addr == 12'hFFF) saw_wrap = 1'b1;
        prev_addr = bram_addr;
      end
      if (win_valid && win_ready) begin
        hs_cnt++;
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_window: got x=%0d y=%0d, required none", win_x, win_y);
        end else begin
          e = q.pop_front();
          chk("win_data", win_data, e.data);
          chk("win_x", 72'(win_x), 72'(e.x));
          chk("win_y", 72'(win_y), 72'(e.y));
          chk("win_last", 72'(win_last), 72'(e.last));
        end
      end
      stall_r = win_valid && !win_ready;
      held.data = win_data;
      held.x = win_x;
      held.y = win_y;
      held.last = win_last;
      if (done) done_cnt++;
    end
  end

  // Monitor for the 8x3 instance.
  always @(negedge clk) begin
    win_t e;
    if (rst) begin
      if (win_valid2 && win_ready2) begin
        if (q2.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL small_extra_window: got x=%0d, required none", win_x2);
        end else begin
          e = q2.pop_front();
          chk("small_data", win_data2, e.data);
          chk("small_x", 72'(win_x2), 72'(e.x));
          chk("small_y", 72'(win_y2), 72'(e.y));
          chk("small_last", 72'(win_last2), 72'(e.last));
        end
      end
      if (done2) done2_cnt++;
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk);
      if (done_cnt > 0) break;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("done_count", 72'(done_cnt), 72'd1);
    chk("windows_pending", 72'(q.size()), 72'd0);
    chk("busy_after_done", 72'(busy), 72'd0);
  endtask

  task automatic run_frame(input logic [11:0] base, input bit inject);
    base_cur = base;
    push_frame();
    done_cnt = 0;
    hs_cnt = 0;
    first_pending = 1'b1;
    first_rd_pending = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = base;
    s_cyc = cyc + 1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", 72'(busy), 72'd1);
    if (inject) begin
      for (int i = 0; i < 3000 && hs_cnt < 50; i++) @(posedge clk);
      #1;
      start = 1'b1;
      base_addr = 12'h123;
      @(posedge clk);
      #1;
      start = 1'b0;
      base_addr = base;
    end
    wait_done();
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    base_addr = 12'h000;
    base_addr2 = 12'h000;
    win_ready2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 72'(busy), 72'd0);
    chk("rst_done", 72'(done), 72'd0);
    chk("rst_bram_en", 72'(bram_en), 72'd0);
    chk("rst_bram_addr", 72'(bram_addr), 72'd0);
    chk("rst_win_valid", 72'(win_valid), 72'd0);
    chk("rst_win_data", win_data, 72'd0);
    chk("rst_win_last", 72'(win_last), 72'd0);
    chk("rst_small_valid", 72'(win_valid2), 72'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // 1: ready held high
    run_frame(12'h000, 1'b0);

    // 2: ready toggling pseudo-randomly
    rand_ready = 1'b1;
    run_frame(12'h000, 1'b0);
    rand_ready = 1'b0;

    // 3: base address wrapping past 0xFFF
    saw_wrap = 1'b0;
    run_frame(12'hFFC, 1'b0);
    chk("addr_wrap_seen", 72'(saw_wrap), 72'd1);

    // 4: second start while busy is ignored
    run_frame(12'h000, 1'b1);

    // 5: reset at window 100, then a fresh frame
    base_cur = 12'h000;
    push_frame();
    done_cnt = 0;
    hs_cnt = 0;
    first_pending = 1'b0;
    first_rd_pending = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = 12'h000;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 3000 && hs_cnt < 100; i++) @(posedge clk);
    #1;
    chk("hs_before_reset", 72'(hs_cnt), 72'd100);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 72'(win_valid), 72'd0);
    chk("mid_rst_busy", 72'(busy), 72'd0);
    chk("mid_rst_data", win_data, 72'd0);
    chk("mid_rst_x", 72'(win_x), 72'd0);
    chk("mid_rst_y", 72'(win_y), 72'd0);
    chk("mid_rst_bram_en", 72'(bram_en), 72'd0);
    q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("no_done_after_reset", 72'(done_cnt), 72'd0);
    chk("idle_after_reset", 72'(busy), 72'd0);
    run_frame(12'h000, 1'b0);

    // 6: smallest map, 8x3
    for (int x = 0; x < 6; x++) begin
      win_t e;
      e.data = exp_win(x, 0);
      e.x = 8'(x);
      e.y = 8'd0;
      e.last = (x == 5);
      q2.push_back(e);
    end
    done2_cnt = 0;
    @(posedge clk);
    #1;
    start2 = 1'b1;
    base_addr2 = base2;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    for (int i = 0; i < 200 && done2_cnt == 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk("small_done_count", 72'(done2_cnt), 72'd1);
    chk("small_pending", 72'(q2.size()), 72'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
